countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//   Loadable WIDTH-bit down-counter/timer. The decrementing counterpart of the
//   4-bit up-counter: accepts a start value over a valid/ready handshake,
//   counts down to zero, pulses expire, then idles or auto-reloads.
//   Used as the interval/timeout source beside the up-counter in formal demos.
// PARAMETERS
//   WIDTH      4   count / load value width
//   EXP_CNT_W  8   width of saturating expiration counter
// PORTS
//   clk          in   1          single clock, rising edge
//   rst_n        in   1          asynchronous active-low reset
//   load_valid   in   1          start request; load_value valid
//   load_ready   out  1          1 only in IDLE
//   load_value   in   WIDTH      initial count N
//   enable       in   1          1: decrement this cycle; 0: hold (pause)
//   reload_en    in   1          sampled at terminal cycle; 1 = reload N
//   abort        in   1          cancel run, no expire
//   count        out  WIDTH      current count (registered)
//   busy         out  1          1 while in RUN
//   expire       out  1          one-cycle registered pulse at terminal count
//   expire_cnt   out  EXP_CNT_W  saturating number of expirations
// BEHAVIOUR
// - rst_n low (async, any time): state=IDLE, count=0, busy=0, expire=0,
//   expire_cnt=0, load_ready=1, stored reload value=0. Run in progress lost.
// - FSM states: IDLE, RUN. All outputs registered except load_ready (=state==IDLE).
// - IDLE: load handshake fires on load_valid&&load_ready at edge k:
//   N>0 -> count=N, reload_reg=N, busy=1, state=RUN after edge k.
//   N==0 -> count=0, expire=1 after edge k, stay IDLE, busy=0.
// - RUN, priority abort > enable:
//   abort=1 -> count=0, busy=0, IDLE, expire=0, expire_cnt unchanged.
//   enable=0 -> hold count; expire=0.
//   enable=1, count>1 -> count-1.
//   enable=1, count==1, reload_en=0 -> count=0, expire=1, busy=0, IDLE.
//   enable=1, count==1, reload_en=1 -> count=reload_reg, expire=1, stay RUN.
// - Latency: load N at edge k, enable held 1 -> expire high after edge k+N;
//   reload period exactly N enabled cycles.
// - count never wraps below 0 (no 0->max transition) and never increases
//   except by load or reload.
// - load_valid during RUN ignored (load_ready=0); no queuing.
// - expire_cnt +1 per expire pulse; saturates at all-ones.
// - expire deasserts the cycle after assertion unless a new terminal
//   event occurs (N=1 reload: expire high every cycle).
// STRUCTURE
// - Package countdown_pkg: typedef enum logic {CD_IDLE, CD_RUN} cd_state_e;
//   default WIDTH / EXP_CNT_W localparams.
// - Sub-module sat_counter #(W) (inc, clear, q) for expire_cnt.
// - `ifdef FORMAL block: assert count==prev-1, hold, load, reload or abort
//   only; assert expire implies prev count==1 or zero load; cover reload
//   wrap N->...->1->N; cover abort at count==1.
// TESTING
// 1. load 5, enable=1, reload_en=0 -> count 5,4,3,2,1,0; expire=1 with
//    count=0; busy=0, load_ready=1 same cycle; expire_cnt=1.
// 2. load 0 in IDLE -> expire=1 next cycle, busy stays 0, count=0.
// 3. load 3, reload_en=1 -> count 3,2,1,3,2,1,3; expire every 3rd cycle;
//    after 4 expiries expire_cnt=4.
// 4. load 15, enable=0 for 4 cycles at count 2 -> count holds 2, no expire;
//    re-enable -> 1, 0 + expire.
// 5. abort with enable=1 at count 1 -> count=0, IDLE, expire never high,
//    expire_cnt unchanged; load_valid while busy -> ignored.
// 6. rst_n low mid-run at count 7 -> all outputs reset immediately
//    (before next edge); after release load 2 runs normally.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and default sizing for the countdown timer.
package countdown_pkg;

  typedef enum logic {CD_IDLE, CD_RUN} cd_state_e;

  localparam int unsigned CD_WIDTH     = 4;
  localparam int unsigned CD_EXP_CNT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones, synchronous clear has priority.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (clear) begin
      q_q <= '0;
    end else if (inc && (q_q != '1)) begin
      q_q <= q_q + W'(1);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter: load N, count to zero, pulse expire, then idle or reload N.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH     = CD_WIDTH,
  parameter int unsigned EXP_CNT_W = CD_EXP_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [WIDTH-1:0]     load_value,
  input  logic                 enable,
  input  logic                 reload_en,
  input  logic                 abort,
  output logic [WIDTH-1:0]     count,
  output logic                 busy,
  output logic                 expire,
  output logic [EXP_CNT_W-1:0] expire_cnt
);

  localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

  cd_state_e        state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             busy_q;
  logic             expire_q;

  logic load_fire;
  logic load_zero;
  logic terminal;
  logic expire_set;

  assign load_fire  = (state_q == CD_IDLE) && load_valid;
  assign load_zero  = load_fire && (load_value == '0);
  assign terminal   = (state_q == CD_RUN) && !abort && enable && (count_q == CountOne);
  assign expire_set = load_zero || terminal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CD_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      expire_q <= expire_set;
      unique case (state_q)
        CD_IDLE: begin
          if (load_fire) begin
            if (load_zero) begin
              count_q <= '0;
            end else begin
              count_q  <= load_value;
              reload_q <= load_value;
              busy_q   <= 1'b1;
              state_q  <= CD_RUN;
            end
          end
        end
        CD_RUN: begin
          if (abort) begin
            count_q <= '0;
            busy_q  <= 1'b0;
            state_q <= CD_IDLE;
          end else if (enable) begin
            if (count_q > CountOne) begin
              count_q <= count_q - CountOne;
            end else if (reload_en) begin
              count_q <= reload_q;
            end else begin
              count_q <= '0;
              busy_q  <= 1'b0;
              state_q <= CD_IDLE;
            end
          end
        end
        default: begin
          state_q <= CD_IDLE;
          busy_q  <= 1'b0;
          count_q <= '0;
        end
      endcase
    end
  end

  // Counter bumps on the same edge that raises expire, so both agree in one cycle.
  sat_counter #(
    .W(EXP_CNT_W)
  ) u_exp_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (expire_set),
    .clear(1'b0),
    .q    (expire_cnt)
  );

  assign load_ready = (state_q == CD_IDLE);
  assign count      = count_q;
  assign busy       = busy_q;
  assign expire     = expire_q;

`ifdef FORMAL
  logic             past_valid_q;
  logic [WIDTH-1:0] prev_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      past_valid_q <= 1'b0;
      prev_count_q <= '0;
    end else begin
      past_valid_q <= 1'b1;
      prev_count_q <= count_q;
    end
  end

  always @(posedge clk) begin
    if (rst_n && past_valid_q) begin
      assert ((count_q == prev_count_q - CountOne) || (count_q == prev_count_q) ||
              (count_q == reload_q) || (count_q == '0));
      assert (!expire_q || (prev_count_q == CountOne) || (count_q == '0));
      cover (expire_q && (state_q == CD_RUN) && (count_q == reload_q) &&
             (reload_q > CountOne));
      cover (state_q == CD_RUN && count_q == CountOne && abort);
    end
  end
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Directed plus random stimulus for countdown_timer, checked against a behavioural model.
module tb_countdown_timer;

  localparam int unsigned WIDTH     = 4;
  localparam int unsigned EXP_CNT_W = 8;
  localparam int          ECNT_MAX  = (1 << EXP_CNT_W) - 1;

  logic                 clk;
  logic                 rst_n;
  logic                 load_valid;
  logic                 load_ready;
  logic [WIDTH-1:0]     load_value;
  logic                 enable;
  logic                 reload_en;
  logic                 abort;
  logic [WIDTH-1:0]     count;
  logic                 busy;
  logic                 expire;
  logic [EXP_CNT_W-1:0] expire_cnt;

  countdown_timer #(
    .WIDTH    (WIDTH),
    .EXP_CNT_W(EXP_CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_value(load_value),
    .enable    (enable),
    .reload_en (reload_en),
    .abort     (abort),
    .count     (count),
    .busy      (busy),
    .expire    (expire),
    .expire_cnt(expire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Behavioural model: a running flag, an integer count and an expiry tally.
  bit m_running;
  int m_count;
  int m_reload;
  bit m_expire;
  int m_ecnt;

  task automatic model_reset();
    m_running = 0;
    m_count   = 0;
    m_reload  = 0;
    m_expire  = 0;
    m_ecnt    = 0;
  endtask

  task automatic model_step();
    m_expire = 0;
    if (!m_running) begin
      if (load_valid) begin
        if (int'(load_value) == 0) begin
          m_expire = 1;
          m_count  = 0;
        end else begin
          m_running = 1;
          m_count   = int'(load_value);
          m_reload  = int'(load_value);
        end
      end
    end else if (abort) begin
      m_running = 0;
      m_count   = 0;
    end else if (enable) begin
      if (m_count > 1) begin
        m_count = m_count - 1;
      end else begin
        m_expire = 1;
        if (reload_en) begin
          m_count = m_reload;
        end else begin
          m_count   = 0;
          m_running = 0;
        end
      end
    end
    if (m_expire && m_ecnt < ECNT_MAX) m_ecnt = m_ecnt + 1;
  endtask

  task automatic check_val(input string tag, input int got, input int want);
    n_checks++;
    assert (got === want) else begin
      n_fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".count"}, int'(count), m_count);
    check_val({tag, ".busy"}, int'(busy), int'(m_running));
    check_val({tag, ".load_ready"}, int'(load_ready), int'(!m_running));
    check_val({tag, ".expire"}, int'(expire), int'(m_expire));
    check_val({tag, ".expire_cnt"}, int'(expire_cnt), m_ecnt);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    load_valid = 0;
    load_value = '0;
    enable     = 1;
    reload_en  = 0;
    abort      = 0;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1;

    // 1: load 5, run to zero without reload.
    load_valid = 1; load_value = 4'd5;
    tick("t1_load");
    load_valid = 0;
    for (int i = 0; i < 5; i++) tick("t1_run");
    check_val("t1_final_expire", int'(expire), 1);
    check_val("t1_final_ecnt", int'(expire_cnt), 1);
    tick("t1_after");

    // 2: zero load expires immediately and stays idle.
    load_valid = 1; load_value = 4'd0;
    tick("t2_load0");
    load_valid = 0;
    check_val("t2_busy", int'(busy), 0);
    check_val("t2_ecnt", int'(expire_cnt), 2);
    tick("t2_after");

    // 3: load 3 with reload, four periods, then stop reloading.
    load_valid = 1; load_value = 4'd3; reload_en = 1;
    tick("t3_load");
    load_valid = 0;
    for (int i = 0; i < 12; i++) tick("t3_reload");
    check_val("t3_ecnt", int'(expire_cnt), 6);
    reload_en = 0;
    for (int i = 0; i < 4; i++) tick("t3_drain");

    // 4: pause at count 2.
    load_valid = 1; load_value = 4'd15;
    tick("t4_load");
    load_valid = 0;
    for (int i = 0; i < 13; i++) tick("t4_down");
    enable = 0;
    for (int i = 0; i < 4; i++) tick("t4_hold");
    check_val("t4_hold_count", int'(count), 2);
    enable = 1;
    for (int i = 0; i < 3; i++) tick("t4_resume");

    // 5: loads ignored while busy, abort at count 1.
    load_valid = 1; load_value = 4'd4;
    tick("t5_load");
    load_value = 4'd9;
    for (int i = 0; i < 3; i++) tick("t5_ignored_load");
    abort = 1;
    tick("t5_abort");
    check_val("t5_abort_expire", int'(expire), 0);
    abort = 0; load_valid = 0;
    tick("t5_after");

    // 6: asynchronous reset mid-run at count 7.
    load_valid = 1; load_value = 4'd10;
    tick("t6_load");
    load_valid = 0;
    for (int i = 0; i < 3; i++) tick("t6_down");
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all("t6_async_reset");
    @(posedge clk);
    #2 rst_n = 1;
    check_all("t6_released");
    load_valid = 1; load_value = 4'd2;
    tick("t6_reload2");
    load_valid = 0;
    for (int i = 0; i < 3; i++) tick("t6_run2");

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      load_valid = ($urandom_range(3) == 0);
      load_value = WIDTH'($urandom);
      enable     = ($urandom_range(3) != 0);
      reload_en  = ($urandom_range(1) == 1);
      abort      = ($urandom_range(15) == 0);
      tick("rand");
    end

    // Saturation of the expiration counter via back-to-back zero loads.
    idle_inputs();
    abort = 1;
    tick("sat_flush");
    abort = 0;
    load_valid = 1; load_value = 4'd0;
    for (int i = 0; i < 300; i++) tick("sat");
    check_val("sat_ecnt_max", int'(expire_cnt), ECNT_MAX);
    idle_inputs();
    tick("sat_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
